serial_readout_receiver: RTL and testbench
==========================================

SERIAL_READOUT_RECEIVER -- requirements
Module: serial_readout_receiver

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 12, giving the bits per pixel counter word (W).
REQ-002 SHALL have parameter PIXELS_PER_CHAIN, default 16, giving the pixels per serial chain (N, N>=2).
REQ-003 SHALL use one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk_read.
REQ-004 SHALL have the following ports:
- clk_read  in  1  readout clock
- reset  in  1  synchronous, active-high reset
- shutter  in  1  pixel counting window; 1 = counting, no readout allowed
- readStart  in  1  one-cycle request to read both chains
- SerOutA  in  1  serial data from chain A
- SerOutB  in  1  serial data from chain B
- shiftEn  out  1  shift enable to the pixel chains; the chains advance one bit per cycle while it is high
- dataA  out  W  assembled chain-A counter word
- dataB  out  W  assembled chain-B counter word
- pixelAddr  out  clog2(N)  index of the word pair on dataA/dataB
- dataValid  out  1  word pair available
- dataReady  in  1  downstream accepts the pair
- busy  out  1  readout in progress
- readoutDone  out  1  one-cycle pulse after the last pair is accepted
- readoutAbort  out  1  one-cycle pulse when a readout is aborted

Function
REQ-005 SHALL implement the FSM states IDLE, SHIFT, DRAIN and DONE.
REQ-006 SHALL move from IDLE to SHIFT on readStart=1 with shutter=0, and SHALL clear the bit counter and the pixel counter at that transition.
REQ-007 SHALL ignore readStart when shutter=1 or when the state is not IDLE.
REQ-008 SHALL, in SHIFT, sample SerOutA and SerOutB on every edge where shiftEn=1 and shift them MSB-first into two W-bit assembly registers.
REQ-009 SHALL drive shiftEn=1 in SHIFT except when bitCnt=W-1 and the output slot is not free; the slot is free when (!dataValid || dataReady).
REQ-010 SHALL, on the edge that samples bit W-1, load both completed words into dataA/dataB, set pixelAddr to the pixel counter, set dataValid=1, and reset bitCnt to 0.
REQ-011 SHALL hold dataA, dataB and pixelAddr stable while dataValid=1 and dataReady=0.
REQ-012 SHALL clear dataValid on the edge where dataValid=dataReady=1, unless a new pair is loaded on the same edge, in which case dataValid SHALL stay 1.
REQ-013 SHALL output pixels in arrival order with pixelAddr 0..N-1; the first pair SHALL appear W cycles after SHIFT entry when there is no backpressure.
REQ-014 SHALL move from SHIFT to DRAIN when pair N-1 is loaded, with shiftEn=0 in DRAIN.
REQ-015 SHALL move from DRAIN to DONE when the final pair is accepted.
REQ-016 SHALL spend exactly one cycle in DONE with readoutDone=1, then return to IDLE.
REQ-017 SHALL take exactly N*W shiftEn-high cycles per full readout, independent of backpressure.
REQ-018 SHALL drive busy=1 in SHIFT, DRAIN and DONE.
REQ-019 SHALL abort when shutter=1 in SHIFT or DRAIN: on the next edge go to IDLE, clear dataValid, drop shiftEn, and pulse readoutAbort for one cycle; readoutDone SHALL NOT pulse.
REQ-020 SHALL give readoutDone=1 and readoutAbort=1 on mutually exclusive cycles.
REQ-021 SHALL keep pixelAddr wrap-free: the pixel counter SHALL stop at N-1 and reset only on a new start.

Reset
REQ-022 SHALL, while reset=1, force state IDLE and drive shiftEn=0, dataValid=0, busy=0, readoutDone=0 and readoutAbort=0; dataA, dataB, pixelAddr and all counters SHALL be 0.
REQ-023 SHALL give reset priority over every other input, including a mid-readout reset, which SHALL discard partial words with no done or abort pulse.
REQ-024 SHALL accept readStart on the first cycle after reset deasserts.

Verification (W=12, N=16)
REQ-025 SHALL be verified for basic readout: shutter=0, readStart pulse, dataReady=1, chain A sends pixel k value 0x100+k and chain B sends 0xF00-k, MSB first -> 16 pairs with pixelAddr 0..15 and matching values, first dataValid 12 cycles after SHIFT entry, readoutDone pulse after pair 15, 192 shiftEn cycles.
REQ-026 SHALL be verified for backpressure: dataReady=0 from pair 3 for 20 cycles -> shiftEn drops after bit 11 of pair 4, pair 3 is held stable, no bits are lost, and all 16 values are correct.
REQ-027 SHALL be verified for abort: shutter raised 50 cycles into SHIFT -> the next cycle shows IDLE, dataValid=0, shiftEn=0, a 1-cycle readoutAbort pulse, and no readoutDone.
REQ-028 SHALL be verified for ignored starts: readStart with shutter=1, and a second readStart during SHIFT -> no state change, and the readout count is unaffected.
REQ-029 SHALL be verified for reset mid-DRAIN: reset with dataValid=1 -> all outputs 0 the next cycle, and readStart is accepted immediately after reset deasserts.
REQ-030 SHALL be verified for simultaneous accept and load: dataReady toggles each cycle -> dataValid never drops across back-to-back pairs when a load coincides with an accept.

Source files
------------

// File: rtl/serial_readout_receiver.sv
// Serial readout receiver: pulls two pixel counter chains MSB-first, assembles
// W-bit words and hands them downstream one pixel pair at a time over a
// valid/ready handshake. The chains are stalled (shiftEn low) rather than
// overrun when the output slot is still occupied at the last bit of a word.
module serial_readout_receiver #(
    parameter int unsigned COUNTER_WIDTH    = 12,
    parameter int unsigned PIXELS_PER_CHAIN = 16
) (
    input  logic                                clk_read,
    input  logic                                reset,
    input  logic                                shutter,
    input  logic                                readStart,
    input  logic                                SerOutA,
    input  logic                                SerOutB,
    output logic                                shiftEn,
    output logic [COUNTER_WIDTH-1:0]            dataA,
    output logic [COUNTER_WIDTH-1:0]            dataB,
    output logic [$clog2(PIXELS_PER_CHAIN)-1:0] pixelAddr,
    output logic                                dataValid,
    input  logic                                dataReady,
    output logic                                busy,
    output logic                                readoutDone,
    output logic                                readoutAbort
);

    localparam int unsigned W   = COUNTER_WIDTH;
    localparam int unsigned N   = PIXELS_PER_CHAIN;
    localparam int unsigned BCW = $clog2(W);
    localparam int unsigned AW  = $clog2(N);

    localparam logic [BCW-1:0] LAST_BIT = BCW'(W - 1);
    localparam logic [AW-1:0]  LAST_PIX = AW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDrain,
        StDone
    } state_t;

    state_t           r_state;
    state_t           w_state_d;
    logic [BCW-1:0]   r_bit_cnt;
    logic [AW-1:0]    r_pix_cnt;
    // Only W-1 bits are kept; the final bit comes straight from the serial input.
    logic [W-2:0]     r_asm_a;
    logic [W-2:0]     r_asm_b;
    logic [W-1:0]     r_data_a;
    logic [W-1:0]     r_data_b;
    logic [AW-1:0]    r_pix_addr;
    logic             r_valid;
    logic             r_abort;

    logic             w_slot_free;
    logic             w_last_bit;
    logic             w_shift_en;
    logic             w_load;
    logic             w_start;
    logic             w_abort;
    logic [W-1:0]     w_word_a;
    logic [W-1:0]     w_word_b;

    // Current word including the bit being sampled this cycle.
    assign w_word_a = {r_asm_a, SerOutA};
    assign w_word_b = {r_asm_b, SerOutB};

    // Next-state and control decode.
    always_comb begin
        w_state_d   = r_state;
        w_shift_en  = 1'b0;
        w_load      = 1'b0;
        w_start     = 1'b0;
        w_abort     = 1'b0;
        w_slot_free = !r_valid || dataReady;
        w_last_bit  = (r_bit_cnt == LAST_BIT);
        unique case (r_state)
            StIdle: begin
                if (readStart && !shutter) begin
                    w_start   = 1'b1;
                    w_state_d = StShift;
                end
            end
            StShift: begin
                if (shutter) begin
                    w_abort   = 1'b1;
                    w_state_d = StIdle;
                end else begin
                    // Stall on the last bit until the previous pair can leave.
                    w_shift_en = !(w_last_bit && !w_slot_free);
                    w_load     = w_shift_en && w_last_bit;
                    if (w_load && (r_pix_cnt == LAST_PIX)) begin
                        w_state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (shutter) begin
                    w_abort   = 1'b1;
                    w_state_d = StIdle;
                end else if (w_slot_free) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_read) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Counters, word assembly and the output holding slot.
    always_ff @(posedge clk_read) begin
        if (reset) begin
            r_bit_cnt  <= '0;
            r_pix_cnt  <= '0;
            r_asm_a    <= '0;
            r_asm_b    <= '0;
            r_data_a   <= '0;
            r_data_b   <= '0;
            r_pix_addr <= '0;
            r_valid    <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_abort <= w_abort;
            if (w_start) begin
                r_bit_cnt <= '0;
                r_pix_cnt <= '0;
            end
            if (w_shift_en) begin
                r_asm_a <= w_word_a[W-2:0];
                r_asm_b <= w_word_b[W-2:0];
                if (w_last_bit) begin
                    r_bit_cnt <= '0;
                    // Saturate so pixelAddr never wraps within a readout.
                    if (r_pix_cnt != LAST_PIX) begin
                        r_pix_cnt <= r_pix_cnt + AW'(1);
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + BCW'(1);
                end
            end
            if (w_abort) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_data_a   <= w_word_a;
                r_data_b   <= w_word_b;
                r_pix_addr <= r_pix_cnt;
                r_valid    <= 1'b1;
            end else if (r_valid && dataReady) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign shiftEn      = w_shift_en && !reset;
    assign busy         = (r_state != StIdle) && !reset;
    assign readoutDone  = (r_state == StDone) && !reset;
    assign readoutAbort = r_abort;
    assign dataA        = r_data_a;
    assign dataB        = r_data_b;
    assign pixelAddr    = r_pix_addr;
    assign dataValid    = r_valid;

endmodule

// File: tb/tb_serial_readout_receiver.sv
// Bench for serial_readout_receiver: models both pixel chains, keeps a
// scoreboard of expected pixel pairs and checks each scenario inline.
module tb_serial_readout_receiver;

    localparam int W  = 12;
    localparam int N  = 16;
    localparam int AW = 4;

    logic          clk_read = 1'b0;
    logic          reset;
    logic          shutter;
    logic          readStart;
    logic          SerOutA;
    logic          SerOutB;
    logic          shiftEn;
    logic [W-1:0]  dataA;
    logic [W-1:0]  dataB;
    logic [AW-1:0] pixelAddr;
    logic          dataValid;
    logic          dataReady;
    logic          busy;
    logic          readoutDone;
    logic          readoutAbort;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
    } pair_t;

    pair_t exp_q[$];

    // Chain model: idx counts bits already shifted out since the last restart.
    int   idx = 0;
    logic chain_rst = 1'b0;

    serial_readout_receiver #(
        .COUNTER_WIDTH   (W),
        .PIXELS_PER_CHAIN(N)
    ) dut (
        .clk_read    (clk_read),
        .reset       (reset),
        .shutter     (shutter),
        .readStart   (readStart),
        .SerOutA     (SerOutA),
        .SerOutB     (SerOutB),
        .shiftEn     (shiftEn),
        .dataA       (dataA),
        .dataB       (dataB),
        .pixelAddr   (pixelAddr),
        .dataValid   (dataValid),
        .dataReady   (dataReady),
        .busy        (busy),
        .readoutDone (readoutDone),
        .readoutAbort(readoutAbort)
    );

    always #5 clk_read = ~clk_read;

    function automatic logic [W-1:0] val_a(input int k);
        return W'(32'h100 + k);
    endfunction

    function automatic logic [W-1:0] val_b(input int k);
        return W'(32'hF00 - k);
    endfunction

    function automatic logic chain_bit(input int i, input logic sel_b);
        logic [W-1:0] v;
        if (i / W >= N) return 1'b0;
        v = sel_b ? val_b(i / W) : val_a(i / W);
        return v[W-1-(i%W)];
    endfunction

    assign SerOutA = chain_bit(idx, 1'b0);
    assign SerOutB = chain_bit(idx, 1'b1);

    // Chains advance one bit on every edge with shiftEn high.
    always @(posedge clk_read) begin
        if (chain_rst) idx <= 0;
        else if (shiftEn) idx <= idx + 1;
    end

    task automatic push_expected();
        pair_t p;
        for (int k = 0; k < N; k++) begin
            p.addr = AW'(k);
            p.a    = val_a(k);
            p.b    = val_b(k);
            exp_q.push_back(p);
        end
    endtask

    // Leaves the caller on the negedge right after the SHIFT-entry edge.
    task automatic start_readout();
        @(negedge clk_read);
        push_expected();
        chain_rst = 1'b1;
        readStart = 1'b1;
        @(negedge clk_read);
        chain_rst = 1'b0;
        readStart = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        shutter   = 1'b0;
        readStart = 1'b0;
        dataReady = 1'b0;
        repeat (3) @(negedge clk_read);
        total++;
        if ({shiftEn, dataValid, busy, readoutDone, readoutAbort} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {shiftEn, dataValid, busy, readoutDone, readoutAbort});
        end
        total++;
        if ({dataA, dataB, pixelAddr} !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h/%h/%0d want 0/0/0", dataA, dataB, pixelAddr);
        end
        reset = 1'b0;
        @(negedge clk_read);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int    first_valid = -1;
        int    done_cnt    = 0;
        int    abort_cnt   = 0;
        pair_t e;
        dataReady = 1'b1;
        start_readout();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy: busy=%b want 1", busy);
        end
        for (int cyc = 1; cyc <= 400 && done_cnt == 0; cyc++) begin
            @(negedge clk_read);
            if (dataValid && first_valid < 0) first_valid = cyc;
            if (readoutDone) done_cnt++;
            if (readoutAbort) abort_cnt++;
            if (dataValid && dataReady) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL basic_extra: addr=%0d with nothing expected", pixelAddr);
                end else begin
                    e = exp_q.pop_front();
                    if (pixelAddr !== e.addr || dataA !== e.a || dataB !== e.b) begin
                        bad++;
                        $display("FAIL basic_pair: got %0d/%h/%h want %0d/%h/%h",
                                 pixelAddr, dataA, dataB, e.addr, e.a, e.b);
                    end
                end
            end
        end
        total++;
        if (first_valid != W) begin
            bad++;
            $display("FAIL basic_latency: got %0d want %0d", first_valid, W);
        end
        total++;
        if (done_cnt != 1 || abort_cnt != 0) begin
            bad++;
            $display("FAIL basic_done: done=%0d abort=%0d want 1/0", done_cnt, abort_cnt);
        end
        total++;
        if (idx != N * W || exp_q.size() != 0) begin
            bad++;
            $display("FAIL basic_count: shifts=%0d left=%0d want %0d/0", idx, exp_q.size(), N * W);
        end
        @(negedge clk_read);
        total++;
        if (readoutDone !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_after: done=%b busy=%b want 0/0", readoutDone, busy);
        end
    endtask

    task automatic test_backpressure();
        int    done_cnt  = 0;
        int    hold_left = 0;
        int    idx_at    = 0;
        bit    held      = 0;
        bit    checked   = 0;
        pair_t e;
        dataReady = 1'b1;
        start_readout();
        for (int cyc = 1; cyc <= 500 && done_cnt == 0; cyc++) begin
            @(negedge clk_read);
            if (held && hold_left == 0 && !checked) begin
                checked = 1;
                total++;
                if (idx - idx_at != W - 1 || shiftEn !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_stall: shifts=%0d shiftEn=%b want %0d/0",
                             idx - idx_at, shiftEn, W - 1);
                end
            end
            if (!held && dataValid && pixelAddr == AW'(3)) begin
                held      = 1;
                hold_left = 20;
                idx_at    = idx;
            end
            if (hold_left > 0) begin
                dataReady = 1'b0;
                hold_left--;
                total++;
                if (dataValid !== 1'b1 || pixelAddr !== AW'(3) ||
                    dataA !== val_a(3) || dataB !== val_b(3)) begin
                    bad++;
                    $display("FAIL bp_hold: got %b/%0d/%h/%h want 1/3/%h/%h",
                             dataValid, pixelAddr, dataA, dataB, val_a(3), val_b(3));
                end
            end else begin
                dataReady = 1'b1;
            end
            #1;
            if (readoutDone) done_cnt++;
            if (dataValid && dataReady) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL bp_extra: addr=%0d with nothing expected", pixelAddr);
                end else begin
                    e = exp_q.pop_front();
                    if (pixelAddr !== e.addr || dataA !== e.a || dataB !== e.b) begin
                        bad++;
                        $display("FAIL bp_pair: got %0d/%h/%h want %0d/%h/%h",
                                 pixelAddr, dataA, dataB, e.addr, e.a, e.b);
                    end
                end
            end
        end
        total++;
        if (!checked || done_cnt != 1 || idx != N * W || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_end: checked=%0d done=%0d shifts=%0d left=%0d want 1/1/%0d/0",
                     checked, done_cnt, idx, exp_q.size(), N * W);
        end
    endtask

    task automatic test_abort();
        pair_t e;
        dataReady = 1'b1;
        start_readout();
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk_read);
            if (dataValid && dataReady) begin
                total++;
                e = exp_q.pop_front();
                if (pixelAddr !== e.addr || dataA !== e.a || dataB !== e.b) begin
                    bad++;
                    $display("FAIL abort_pair: got %0d/%h/%h want %0d/%h/%h",
                             pixelAddr, dataA, dataB, e.addr, e.a, e.b);
                end
            end
        end
        shutter = 1'b1;
        @(negedge clk_read);
        shutter = 1'b0;
        total++;
        if ({busy, dataValid, shiftEn, readoutAbort, readoutDone} !== 5'b00010) begin
            bad++;
            $display("FAIL abort_now: busy/valid/shiftEn/abort/done=%b want 00010",
                     {busy, dataValid, shiftEn, readoutAbort, readoutDone});
        end
        @(negedge clk_read);
        total++;
        if ({busy, readoutAbort, readoutDone} !== 3'b000) begin
            bad++;
            $display("FAIL abort_pulse: busy/abort/done=%b want 000",
                     {busy, readoutAbort, readoutDone});
        end
        exp_q.delete();
    endtask

    task automatic test_ignored_start();
        int    done_cnt = 0;
        pair_t e;
        @(negedge clk_read);
        shutter   = 1'b1;
        readStart = 1'b1;
        @(negedge clk_read);
        readStart = 1'b0;
        total++;
        if (busy !== 1'b0 || shiftEn !== 1'b0) begin
            bad++;
            $display("FAIL ign_shutter: busy=%b shiftEn=%b want 0/0", busy, shiftEn);
        end
        shutter   = 1'b0;
        dataReady = 1'b1;
        start_readout();
        for (int cyc = 1; cyc <= 400 && done_cnt == 0; cyc++) begin
            @(negedge clk_read);
            readStart = (cyc == 30);
            if (readoutDone) done_cnt++;
            if (dataValid && dataReady) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL ign_extra: addr=%0d with nothing expected", pixelAddr);
                end else begin
                    e = exp_q.pop_front();
                    if (pixelAddr !== e.addr || dataA !== e.a || dataB !== e.b) begin
                        bad++;
                        $display("FAIL ign_pair: got %0d/%h/%h want %0d/%h/%h",
                                 pixelAddr, dataA, dataB, e.addr, e.a, e.b);
                    end
                end
            end
        end
        readStart = 1'b0;
        total++;
        if (done_cnt != 1 || idx != N * W || exp_q.size() != 0) begin
            bad++;
            $display("FAIL ign_end: done=%0d shifts=%0d left=%0d want 1/%0d/0",
                     done_cnt, idx, exp_q.size(), N * W);
        end
    endtask

    task automatic test_reset_drain();
        int    done_cnt = 0;
        bit    hit      = 0;
        pair_t e;
        dataReady = 1'b1;
        start_readout();
        for (int cyc = 1; cyc <= 400 && !hit; cyc++) begin
            @(negedge clk_read);
            if (dataValid && pixelAddr == AW'(N - 1)) begin
                hit = 1;
            end else if (dataValid && dataReady) begin
                e = exp_q.pop_front();
                total++;
                if (pixelAddr !== e.addr || dataA !== e.a || dataB !== e.b) begin
                    bad++;
                    $display("FAIL rd_pair: got %0d/%h/%h want %0d/%h/%h",
                             pixelAddr, dataA, dataB, e.addr, e.a, e.b);
                end
            end
        end
        total++;
        if (!hit || busy !== 1'b1) begin
            bad++;
            $display("FAIL rd_reach: reached=%0d busy=%b want 1/1", hit, busy);
        end
        dataReady = 1'b0;
        reset     = 1'b1;
        exp_q.delete();
        @(negedge clk_read);
        total++;
        if ({shiftEn, dataValid, busy, readoutDone, readoutAbort, dataA, dataB, pixelAddr} !== '0)
        begin
            bad++;
            $display("FAIL rd_zero: ctrl=%b data=%h/%h/%0d want all 0",
                     {shiftEn, dataValid, busy, readoutDone, readoutAbort},
                     dataA, dataB, pixelAddr);
        end
        reset     = 1'b0;
        readStart = 1'b1;
        chain_rst = 1'b1;
        dataReady = 1'b1;
        push_expected();
        @(negedge clk_read);
        readStart = 1'b0;
        chain_rst = 1'b0;
        total++;
        if (busy !== 1'b1 || readoutAbort !== 1'b0) begin
            bad++;
            $display("FAIL rd_restart: busy=%b abort=%b want 1/0", busy, readoutAbort);
        end
        for (int cyc = 1; cyc <= 400 && done_cnt == 0; cyc++) begin
            @(negedge clk_read);
            if (readoutDone) done_cnt++;
            if (dataValid && dataReady) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rd_extra: addr=%0d with nothing expected", pixelAddr);
                end else begin
                    e = exp_q.pop_front();
                    if (pixelAddr !== e.addr || dataA !== e.a || dataB !== e.b) begin
                        bad++;
                        $display("FAIL rd_pair2: got %0d/%h/%h want %0d/%h/%h",
                                 pixelAddr, dataA, dataB, e.addr, e.a, e.b);
                    end
                end
            end
        end
        total++;
        if (done_cnt != 1 || idx != N * W || exp_q.size() != 0) begin
            bad++;
            $display("FAIL rd_end: done=%0d shifts=%0d left=%0d want 1/%0d/0",
                     done_cnt, idx, exp_q.size(), N * W);
        end
    endtask

    task automatic test_back_to_back();
        int    done_cnt   = 0;
        int    coincide   = 0;
        bit    tog        = 0;
        bit    expect_hold = 0;
        pair_t e;
        dataReady = 1'b0;
        start_readout();
        for (int cyc = 1; cyc <= 600 && done_cnt == 0; cyc++) begin
            @(negedge clk_read);
            if (expect_hold) begin
                total++;
                if (dataValid !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_valid_drop: dataValid=%b want 1 at shift %0d",
                             dataValid, idx);
                end
            end
            tog       = !tog;
            // Ready only pulses while the next word is waiting on its last bit.
            dataReady = tog && ((idx % W == W - 1) || idx == N * W);
            #1;
            expect_hold = dataValid && dataReady && shiftEn && (idx % W == W - 1);
            if (expect_hold) coincide++;
            if (readoutDone) done_cnt++;
            if (dataValid && dataReady) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra: addr=%0d with nothing expected", pixelAddr);
                end else begin
                    e = exp_q.pop_front();
                    if (pixelAddr !== e.addr || dataA !== e.a || dataB !== e.b) begin
                        bad++;
                        $display("FAIL b2b_pair: got %0d/%h/%h want %0d/%h/%h",
                                 pixelAddr, dataA, dataB, e.addr, e.a, e.b);
                    end
                end
            end
        end
        total++;
        if (coincide != N - 1 || done_cnt != 1 || idx != N * W || exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_end: coincide=%0d done=%0d shifts=%0d left=%0d want %0d/1/%0d/0",
                     coincide, done_cnt, idx, exp_q.size(), N - 1, N * W);
        end
        dataReady = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_ignored_start();
        test_reset_drain();
        test_back_to_back();
        repeat (2) @(negedge clk_read);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
